// File: rtl/sr_latch_arbiter.sv
// sr_latch_arbiter: round-robin arbiter that serialises set/clear operations onto a bank of SR latches
module sr_latch_arbiter #(
    parameter int NREQ   = 4,
    parameter int NLATCH = 8,
    parameter int IW     = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      set_op,
    input  logic [NREQ*IW-1:0]   idx,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [NLATCH-1:0]    lat_s,
    output logic [NLATCH-1:0]    lat_r,
    output logic [NLATCH-1:0]    lat_en,
    output logic                 lat_rst,
    output logic [NLATCH-1:0]    shadow,
    output logic                 busy
);
    localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
    state_t              state;
    logic [PW-1:0]       ptr;
    logic [PW-1:0]       win;
    logic                op_cap;
    logic [PW-1:0]       win_n;
    logic                found_n;
    logic [IW-1:0]       idx_n;
    logic                op_n;
    logic [NLATCH-1:0]   sel_n;
    logic                chg_n;
    assign busy = state != IDLE;
    // round-robin search from ptr, then decode the winner's latch and decide whether a drive is needed
    always_comb begin
        win_n   = ptr;
        found_n = 1'b0;
        idx_n   = '0;
        for (int i = 0; i < NREQ; i++) begin
            logic [PW-1:0] j;
            j = PW'((32'(ptr) + 32'(i)) % NREQ);
            if (!found_n && req[j]) begin
                win_n   = j;
                found_n = 1'b1;
            end
        end
        for (int k = 0; k < NREQ; k++)
            if (win_n == PW'(k)) idx_n = idx[k*IW +: IW];
        op_n  = set_op[win_n];
        sel_n = (32'(idx_n) < NLATCH) ? NLATCH'(1) << idx_n : '0;
        chg_n = |(sel_n & (shadow ^ {NLATCH{op_n}}));
    end
    // control FSM; lat_en holds the captured latch select during DRIVE and is reused for the shadow update
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            gnt     <= '0;
            done    <= '0;
            lat_s   <= '0;
            lat_r   <= '0;
            lat_en  <= '0;
            shadow  <= '0;
            ptr     <= '0;
            win     <= '0;
            op_cap  <= 1'b0;
            lat_rst <= 1'b1;
        end else begin
            lat_rst <= 1'b0;
            case (state)
                IDLE: if (found_n) begin
                    win    <= win_n;
                    op_cap <= op_n;
                    gnt    <= NREQ'(1) << win_n;
                    if (chg_n) begin
                        state  <= DRIVE;
                        lat_en <= sel_n;
                        lat_s  <= op_n ? sel_n : '0;
                        lat_r  <= op_n ? '0 : sel_n;
                    end else begin
                        state <= DONE;
                        done  <= NREQ'(1) << win_n;
                    end
                end
                DRIVE: begin
                    state  <= DONE;
                    done   <= gnt;
                    lat_en <= '0;
                    lat_s  <= '0;
                    lat_r  <= '0;
                    shadow <= op_cap ? shadow | lat_en : shadow & ~lat_en;
                end
                DONE: begin
                    state <= IDLE;
                    gnt   <= '0;
                    done  <= '0;
                    ptr   <= (32'(win) == NREQ - 1) ? '0 : win + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sr_latch_arbiter.sv
// tb_sr_latch_arbiter: randomized and directed checks of sr_latch_arbiter against a transaction-level model
module tb_sr_latch_arbiter;
    localparam int NREQ = 4, NLATCH = 8, IW = 4;
    logic clk = 1'b0, reset = 1'b1, lat_rst, busy;
    logic [NREQ-1:0] req = '0, set_op = '0, gnt, done;
    logic [NREQ*IW-1:0] idx = '0;
    logic [NLATCH-1:0] lat_s, lat_r, lat_en, shadow;
    int n_chk = 0, n_fail = 0;
    typedef struct {
        logic [NREQ-1:0]   gnt, done;
        logic [NLATCH-1:0] s, r, en, sh;
        logic              busy, lrst;
    } exp_t;
    exp_t q[$];
    exp_t e;
    logic [NLATCH-1:0] sh_m = '0;
    int ptr_m = 0;

    sr_latch_arbiter #(.NREQ(NREQ), .NLATCH(NLATCH), .IW(IW)) dut (
        .clk(clk), .reset(reset), .req(req), .set_op(set_op), .idx(idx),
        .gnt(gnt), .done(done), .lat_s(lat_s), .lat_r(lat_r), .lat_en(lat_en),
        .lat_rst(lat_rst), .shadow(shadow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // advance the model one edge using the inputs the DUT samples at that edge
    task automatic model_edge();
        exp_t z;
        z = '{default: '0};
        if (reset) begin
            q.delete();
            ptr_m = 0;
            e = z;
            e.lrst = 1'b1;
        end else if (q.size() > 0) begin
            e = q.pop_front();
        end else if (req != 0) begin
            int k, v;
            bit o;
            logic [NLATCH-1:0] nsh;
            exp_t d;
            k = -1;
            for (int i = 0; i < NREQ; i++)
                if (k < 0 && req[(ptr_m + i) % NREQ]) k = (ptr_m + i) % NREQ;
            v = int'(idx[k*IW +: IW]);
            o = set_op[k];
            nsh = sh_m;
            if (v < NLATCH) nsh[v] = o;
            d = z;
            d.gnt = NREQ'(1 << k);
            d.busy = 1'b1;
            d.sh = sh_m;
            if (nsh != sh_m) begin
                d.en = NLATCH'(1 << v);
                d.s = o ? d.en : '0;
                d.r = o ? '0 : d.en;
                q.push_back(d);
                d.en = '0; d.s = '0; d.r = '0;
            end
            d.done = d.gnt;
            d.sh = nsh;
            q.push_back(d);
            z.sh = nsh;
            q.push_back(z);
            ptr_m = (k + 1) % NREQ;
            e = q.pop_front();
        end else begin
            e = z;
            e.sh = sh_m;
        end
        sh_m = e.sh;
    endtask

    task automatic step(input logic r, input logic [NREQ-1:0] rq, input logic [NREQ-1:0] op, input logic [NREQ*IW-1:0] ix);
        reset = r; req = rq; set_op = op; idx = ix;
        @(posedge clk);
        model_edge();
        #1;
        check("gnt", 32'(gnt), 32'(e.gnt));
        check("done", 32'(done), 32'(e.done));
        check("lat_s", 32'(lat_s), 32'(e.s));
        check("lat_r", 32'(lat_r), 32'(e.r));
        check("lat_en", 32'(lat_en), 32'(e.en));
        check("shadow", 32'(shadow), 32'(e.sh));
        check("busy", 32'(busy), 32'(e.busy));
        check("lat_rst", 32'(lat_rst), 32'(e.lrst));
        check("sr_excl", 32'(lat_s & lat_r), 32'(0));
        check("en_onehot0", 32'($onehot0(lat_en)), 32'(1));
    endtask

    initial begin
        repeat (2) step(1, 0, 0, 0);
        step(0, 4'b0001, 4'b0001, 16'h5555);
        repeat (4) step(0, 0, 0, 0);
        step(0, 4'b0001, 4'b0001, 16'h5555);
        repeat (3) step(0, 0, 0, 0);
        step(0, 4'b0100, 4'b0100, 16'h3333);
        repeat (3) step(0, 0, 0, 0);
        step(0, 4'b0100, 4'b0000, 16'h3333);
        repeat (3) step(0, 0, 0, 0);
        step(0, 4'b0001, 4'b0001, 16'h9999);
        repeat (3) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        repeat (16) step(0, 4'b1111, 4'b1111, 16'h7531);
        step(1, 0, 0, 0);
        step(0, 4'b0001, 4'b0001, 16'h1111);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            logic [NREQ*IW-1:0] ix;
            for (int k = 0; k < NREQ; k++) ix[k*IW +: IW] = IW'($urandom_range(0, 9));
            step($urandom_range(0, 59) == 0, NREQ'($urandom), NREQ'($urandom), ix);
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
